// File: rtl/ws_pkg.sv
// ws_pkg: shared definitions for the weight-stationary PE datapath.
//   DW       activation/weight/product width (signed)
//   FRAC     fractional bits of the weight format
//   state_t  PE row control states
//   SAT_MAX  upper saturation bound of a DW-bit signed product
//   SAT_MIN  lower saturation bound of a DW-bit signed product
package ws_pkg;

  localparam int DW   = 8;
  localparam int FRAC = 4;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int SAT_MAX = (1 << (DW - 1)) - 1;
  localparam int SAT_MIN = -(1 << (DW - 1));

endpackage

// File: rtl/ws_mul_sat.sv
// ws_mul_sat: signed DW x DW multiply, arithmetic shift right by FRAC
// (floor), saturate to the DW-bit signed range. Purely combinational.
//   a_i  in   DW  signed activation
//   w_i  in   DW  signed weight
//   p_o  out  DW  signed scaled, saturated product
module ws_mul_sat #(
  parameter int DW   = ws_pkg::DW,
  parameter int FRAC = ws_pkg::FRAC
) (
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] w_i,
  output logic signed [DW-1:0] p_o
);

  // Saturation bounds expressed at full product width.
  localparam logic signed [2*DW-1:0] HI = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW-1:0] LO = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [2*DW-1:0] prod;
  logic signed [2*DW-1:0] shr;

  always_comb begin
    prod = (2*DW)'(a_i) * (2*DW)'(w_i);
    shr  = prod >>> FRAC;
    if (shr > HI) begin
      p_o = HI[DW-1:0];
    end else if (shr < LO) begin
      p_o = LO[DW-1:0];
    end else begin
      p_o = shr[DW-1:0];
    end
  end

endmodule

// File: rtl/ws_pe_row.sv
// ws_pe_row: weight-stationary processing-element row. Loads three signed
// weights, then streams activations through a 3-tap window and emits three
// registered scaled products per accepted activation.
//   sys_clk   in   clock, rising edge
//   CLR_n     in   asynchronous active-low reset
//   w_valid   in   weight word offered
//   w_ready   out  weight accepted (LOAD state)
//   w_data    in   signed weight word (1st->W1, 2nd->W2, 3rd->W3)
//   a_valid   in   activation offered
//   a_ready   out  activation accepted (RUN and no reload)
//   a_data    in   signed activation
//   reload    in   return to LOAD, discarding the current window
//   P1..P3    out  registered products a*W1, tap0*W2, tap1*W3
//   p_valid   out  one-cycle pulse when P1..P3 hold a full-window result
module ws_pe_row
  import ws_pkg::*;
#(
  parameter int DW   = ws_pkg::DW,
  parameter int FRAC = ws_pkg::FRAC
) (
  input  logic                 sys_clk,
  input  logic                 CLR_n,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic signed [DW-1:0] w_data,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic signed [DW-1:0] a_data,
  input  logic                 reload,
  output logic signed [DW-1:0] P1,
  output logic signed [DW-1:0] P2,
  output logic signed [DW-1:0] P3,
  output logic                 p_valid
);

  state_t state_q, state_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic [1:0] fill_q, fill_d;
  logic signed [DW-1:0] w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
  logic signed [DW-1:0] tap0_q, tap0_d, tap1_q, tap1_d;
  logic signed [DW-1:0] p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic signed [DW-1:0] m1, m2, m3;
  logic pv_q, pv_d;
  logic a_acc;

  ws_mul_sat #(.DW(DW), .FRAC(FRAC)) u_mul1 (.a_i(a_data), .w_i(w1_q), .p_o(m1));
  ws_mul_sat #(.DW(DW), .FRAC(FRAC)) u_mul2 (.a_i(tap0_q), .w_i(w2_q), .p_o(m2));
  ws_mul_sat #(.DW(DW), .FRAC(FRAC)) u_mul3 (.a_i(tap1_q), .w_i(w3_q), .p_o(m3));

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    fill_d  = fill_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    w3_d    = w3_q;
    tap0_d  = tap0_q;
    tap1_d  = tap1_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    p3_d    = p3_q;
    pv_d    = 1'b0;

    w_ready = (state_q == LOAD);
    a_ready = (state_q == RUN) && !reload;
    a_acc   = a_valid && a_ready;

    unique case (state_q)
      LOAD: begin
        // reload wins over a coincident weight beat: loading restarts at W1.
        if (reload) begin
          wcnt_d = '0;
        end else if (w_valid) begin
          unique case (wcnt_q)
            2'd0: begin
              w1_d   = w_data;
              wcnt_d = 2'd1;
            end
            2'd1: begin
              w2_d   = w_data;
              wcnt_d = 2'd2;
            end
            default: begin
              w3_d    = w_data;
              wcnt_d  = '0;
              state_d = RUN;
            end
          endcase
        end
      end
      RUN: begin
        if (reload) begin
          state_d = LOAD;
          wcnt_d  = '0;
          fill_d  = '0;
          tap0_d  = '0;
          tap1_d  = '0;
        end else if (a_acc) begin
          tap0_d = a_data;
          tap1_d = tap0_q;
          p1_d   = m1;
          p2_d   = m2;
          p3_d   = m3;
          fill_d = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
          pv_d   = (fill_q >= 2'd2);
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge sys_clk or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q <= LOAD;
      wcnt_q  <= '0;
      fill_q  <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
      tap0_q  <= '0;
      tap1_q  <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      p3_q    <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      fill_q  <= fill_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      w3_q    <= w3_d;
      tap0_q  <= tap0_d;
      tap1_q  <= tap1_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      p3_q    <= p3_d;
      pv_q    <= pv_d;
    end
  end

  assign P1      = p1_q;
  assign P2      = p2_q;
  assign P3      = p3_q;
  assign p_valid = pv_q;

endmodule

// File: tb/tb_ws_pe_row.sv
module tb_ws_pe_row;
  import ws_pkg::*;

  logic              sys_clk = 1'b0;
  logic              CLR_n   = 1'b0;
  logic              w_valid = 1'b0;
  logic              w_ready;
  logic signed [7:0] w_data  = '0;
  logic              a_valid = 1'b0;
  logic              a_ready;
  logic signed [7:0] a_data  = '0;
  logic              reload  = 1'b0;
  logic signed [7:0] P1, P2, P3;
  logic              p_valid;

  int total = 0;
  int bad   = 0;

  ws_pe_row #(.DW(8), .FRAC(4)) dut (
    .sys_clk(sys_clk), .CLR_n(CLR_n),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .reload(reload),
    .P1(P1), .P2(P2), .P3(P3), .p_valid(p_valid)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic wv; int wd; logic av; int ad; logic rl;
    logic ewr; logic ear; logic epv;
    logic chkp; int e1; int e2; int e3;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic wv, int wd, logic av, int ad, logic rl,
                              logic ewr, logic ear, logic epv,
                              logic chkp, int e1, int e2, int e3);
    vec_t v;
    v.wv = wv; v.wd = wd; v.av = av; v.ad = ad; v.rl = rl;
    v.ewr = ewr; v.ear = ear; v.epv = epv;
    v.chkp = chkp; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wbeat(input int d);
    w_valid = 1'b1; w_data = 8'(d);
    step();
    w_valid = 1'b0;
  endtask

  task automatic abeat(input int d);
    a_valid = 1'b1; a_data = 8'(d);
    step();
    a_valid = 1'b0;
  endtask

  task automatic check_p(input string tag, input int e1, input int e2, input int e3, input int epv);
    check({tag, "_P1"}, int'(P1), e1);
    check({tag, "_P2"}, int'(P2), e2);
    check({tag, "_P3"}, int'(P3), e3);
    check({tag, "_pv"}, int'(p_valid), epv);
  endtask

  initial begin
    // Basic window with W=1.0, gaps, reload priority, fresh window with W=2.0.
    tbl[0]  = mk(1, 16, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0);
    tbl[1]  = mk(1, 16, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0);
    tbl[2]  = mk(1, 16, 0, 0, 0,  0, 1, 0,  1, 0, 0, 0);
    tbl[3]  = mk(0, 0,  1, 1, 0,  0, 1, 0,  1, 1, 0, 0);
    tbl[4]  = mk(0, 0,  1, 2, 0,  0, 1, 0,  1, 2, 1, 0);
    tbl[5]  = mk(0, 0,  1, 3, 0,  0, 1, 1,  1, 3, 2, 1);
    tbl[6]  = mk(0, 0,  1, 4, 0,  0, 1, 1,  1, 4, 3, 2);
    tbl[7]  = mk(0, 0,  0, 0, 0,  0, 1, 0,  1, 4, 3, 2);
    tbl[8]  = mk(0, 0,  1, 5, 0,  0, 1, 1,  1, 5, 4, 3);
    tbl[9]  = mk(0, 0,  1, 9, 1,  1, 0, 0,  0, 0, 0, 0);
    tbl[10] = mk(1, 32, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0);
    tbl[11] = mk(1, 32, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0);
    tbl[12] = mk(1, 32, 0, 0, 0,  0, 1, 0,  0, 0, 0, 0);
    tbl[13] = mk(0, 0,  1, 1, 0,  0, 1, 0,  1, 2, 0, 0);
    tbl[14] = mk(0, 0,  1, 1, 0,  0, 1, 0,  1, 2, 2, 0);
    tbl[15] = mk(0, 0,  1, 1, 0,  0, 1, 1,  1, 2, 2, 2);
    tbl[16] = mk(0, 0,  0, 0, 0,  0, 1, 0,  1, 2, 2, 2);
    tbl[17] = mk(0, 0,  0, 0, 0,  0, 1, 0,  1, 2, 2, 2);
    tbl[18] = mk(0, 0,  1, 3, 0,  0, 1, 1,  1, 6, 2, 2);
    tbl[19] = mk(0, 0,  0, 0, 0,  0, 1, 0,  1, 6, 2, 2);

    // Reset state.
    #2;
    check("rst_wready", int'(w_ready), 1);
    check("rst_aready", int'(a_ready), 0);
    check_p("rst", 0, 0, 0, 0);
    @(negedge sys_clk);
    CLR_n = 1'b1;
    step();

    for (int i = 0; i < 20; i++) begin
      w_valid = tbl[i].wv; w_data = 8'(tbl[i].wd);
      a_valid = tbl[i].av; a_data = 8'(tbl[i].ad);
      reload  = tbl[i].rl;
      step();
      check($sformatf("v%0d_wready", i), int'(w_ready), int'(tbl[i].ewr));
      check($sformatf("v%0d_aready", i), int'(a_ready), int'(tbl[i].ear));
      check($sformatf("v%0d_pvalid", i), int'(p_valid), int'(tbl[i].epv));
      if (tbl[i].chkp) begin
        check($sformatf("v%0d_P1", i), int'(P1), tbl[i].e1);
        check($sformatf("v%0d_P2", i), int'(P2), tbl[i].e2);
        check($sformatf("v%0d_P3", i), int'(P3), tbl[i].e3);
      end
    end
    w_valid = 1'b0; a_valid = 1'b0; reload = 1'b0;

    // Reset mid-load: two beats, async clear, then load from scratch.
    reload = 1'b1; step(); reload = 1'b0;
    wbeat(50);
    wbeat(60);
    #2;
    CLR_n = 1'b0;
    #1;
    check("midrst_aready", int'(a_ready), 0);
    check_p("midrst", 0, 0, 0, 0);
    @(negedge sys_clk);
    CLR_n = 1'b1;
    wbeat(127);
    wbeat(-128);
    check("midrst_still_load", int'(w_ready), 1);
    wbeat(1);
    check("midrst_run", int'(a_ready), 1);
    // 127*127=16129>>4=1008 -> SAT_MAX; P2/P3 from cleared taps.
    abeat(127);
    check_p("sat_hi", SAT_MAX, 0, 0, 0);
    // 127*-1=-127>>4 floors to -8; 127*-128=-16256>>4=-1016 -> SAT_MIN.
    abeat(-1);
    check_p("floor_sat_lo", -8, SAT_MIN, 0, 0);
    // P2 = -1*-128=128>>4=8; P3 = 127*1=127>>4=7.
    abeat(0);
    check_p("third", 0, 8, 7, 1);

    // Second weight set: W1=-128, W2=1, W3=1.
    reload = 1'b1; step(); reload = 1'b0;
    wbeat(-128);
    wbeat(1);
    wbeat(1);
    abeat(127);
    check_p("sat_lo", SAT_MIN, 0, 0, 0);
    abeat(-1);
    check_p("w2_sat", 8, 7, 0, 0);
    // P2 = -1*1 = -1>>4 floors to -1.
    abeat(0);
    check_p("floor_neg1", 0, -1, 7, 1);
    step();
    check("pv_drop", int'(p_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
